// File: rtl/dmem_store_tracer_if.sv
// Bus bundle between the processor->dmem snoop point and the store tracer.
//   Snoop side : addr_to_mem, data_to_mem, write_enable, byte_to_mem,
//                half_word_to_mem (driven by the processor, only observed here)
//   Trace side : trace_valid/trace_ready handshake with trace_addr,
//                trace_data, trace_size, trace_seq payload
// master = environment (processor + trace consumer); slave = the tracer.
interface dmem_store_tracer_if;
  logic [31:0] addr_to_mem;
  logic [31:0] data_to_mem;
  logic        write_enable;
  logic        byte_to_mem;
  logic        half_word_to_mem;

  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic [1:0]  trace_size;
  logic [15:0] trace_seq;

  modport master (
    output addr_to_mem, data_to_mem, write_enable, byte_to_mem, half_word_to_mem,
    output trace_ready,
    input  trace_valid, trace_addr, trace_data, trace_size, trace_seq
  );

  modport slave (
    input  addr_to_mem, data_to_mem, write_enable, byte_to_mem, half_word_to_mem,
    input  trace_ready,
    output trace_valid, trace_addr, trace_data, trace_size, trace_seq
  );
endinterface

// File: rtl/dmem_store_tracer.sv
// Passive store tracer on the processor->dmem port. Every committed store
// inside [ADDR_LO, ADDR_HI] is queued (address, data, size, sequence number)
// and drained over a valid/ready trace port. The processor is never stalled:
// a store arriving at a full FIFO with no simultaneous pop is dropped and
// counted instead.
// Ports:
//   clock       rising-edge clock shared with processor/dmem
//   reset       asynchronous, active-low
//   trace_en    1 = capture stores, 0 = ignore new stores (queue still drains)
//   bus         snoop inputs and trace handshake (slave modport)
//   drop_count  stores lost to a full FIFO, saturating
//   overflow    sticky flag, set on the first drop
//   level       current FIFO occupancy, 0..DEPTH
module dmem_store_tracer #(
  parameter int          DEPTH   = 16,
  parameter logic [31:0] ADDR_LO = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI = 32'hFFFF_FFFF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     trace_en,
  dmem_store_tracer_if.slave       bus,
  output logic [15:0]              drop_count,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [15:0] seq;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             head_q, head_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [15:0]        seq_q, seq_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;
  logic               ovf_q, ovf_d;

  logic [32:0]        lo_diff, hi_diff;
  logic               in_range, store_evt, full, empty, pop, push, drop, head_load;
  entry_t             new_entry;

  always_comb begin
    // Range test via 33-bit differences: a clear borrow bit means the bound holds.
    lo_diff  = {1'b0, bus.addr_to_mem} - {1'b0, ADDR_LO};
    hi_diff  = {1'b0, ADDR_HI} - {1'b0, bus.addr_to_mem};
    in_range = !lo_diff[32] && !hi_diff[32];

    // An unknown strobe falls into the else path and is not a store.
    store_evt = 1'b0;
    if (bus.write_enable) store_evt = trace_en && in_range;

    new_entry.addr = bus.addr_to_mem;
    new_entry.data = bus.data_to_mem;
    new_entry.seq  = seq_q;
    if (bus.byte_to_mem)           new_entry.size = 2'd2;
    else if (bus.half_word_to_mem) new_entry.size = 2'd1;
    else                           new_entry.size = 2'd0;

    full  = (level_q == FULL_LVL);
    empty = (level_q == '0);
    pop   = !empty && bus.trace_ready;
    // A pop on a full FIFO frees the slot in the same edge, so the push fits.
    push  = store_evt && (!full || pop);
    drop  = store_evt && full && !pop;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    seq_d      = store_evt ? seq_q + 16'd1 : seq_q;
    drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    ovf_d      = ovf_q | drop;

    // The head register is refreshed whenever the head slot changes and the
    // FIFO stays non-empty. If the new head is the slot being written this
    // edge, it is taken straight from the incoming store.
    head_load = (level_d != '0) && (pop || empty);
    head_d    = head_q;
    if (head_load) begin
      if (push && (rd_ptr_d == wr_ptr_q)) head_d = new_entry;
      else                                head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      seq_q      <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
      head_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      seq_q      <= seq_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
      head_q     <= head_d;
    end
  end

  // Storage is not reset; only pointers and occupancy define what is live.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

  assign bus.trace_valid = (level_q != '0);
  assign bus.trace_addr  = head_q.addr;
  assign bus.trace_data  = head_q.data;
  assign bus.trace_size  = head_q.size;
  assign bus.trace_seq   = head_q.seq;
  assign drop_count      = drop_cnt_q;
  assign overflow        = ovf_q;
  assign level           = level_q;

endmodule

// File: tb/tb_dmem_store_tracer.sv
module tb_dmem_store_tracer;
  localparam int DEPTH = 16;

  logic        clock;
  logic        reset;
  logic        en1, en2;
  logic [15:0] drop1, drop2;
  logic        ovf1, ovf2;
  logic [4:0]  lvl1, lvl2;

  dmem_store_tracer_if bus1();
  dmem_store_tracer_if bus2();

  dmem_store_tracer #(.DEPTH(DEPTH)) dut1 (
    .clock(clock), .reset(reset), .trace_en(en1), .bus(bus1),
    .drop_count(drop1), .overflow(ovf1), .level(lvl1)
  );

  dmem_store_tracer #(.DEPTH(DEPTH), .ADDR_LO(32'h0000_2000), .ADDR_HI(32'h0000_20FF)) dut2 (
    .clock(clock), .reset(reset), .trace_en(en2), .bus(bus2),
    .drop_count(drop2), .overflow(ovf2), .level(lvl2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic st1(input logic [31:0] a, input logic [31:0] d, input logic b, input logic h);
    bus1.addr_to_mem = a;
    bus1.data_to_mem = d;
    bus1.byte_to_mem = b;
    bus1.half_word_to_mem = h;
    bus1.write_enable = 1'b1;
  endtask

  task automatic st2(input logic [31:0] a, input logic [31:0] d);
    bus2.addr_to_mem = a;
    bus2.data_to_mem = d;
    bus2.byte_to_mem = 1'b0;
    bus2.half_word_to_mem = 1'b0;
    bus2.write_enable = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Scoreboard for dut1: entries are queued when a store is presented and
  // compared when the model says the head is consumed.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [15:0] seq;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mseq;
  logic [15:0] mdrop;
  logic        movf;

  always @(negedge clock) begin
    exp_t e;
    logic pop_m;
    if (!reset) begin
      exp_q.delete();
      mseq = '0; mdrop = '0; movf = 1'b0;
    end else begin
      chk("sb_level", 32'(lvl1), 32'(exp_q.size()));
      chk("sb_drops", 32'(drop1), 32'(mdrop));
      chk("sb_ovf", 32'(ovf1), 32'(movf));
      chk("sb_valid", 32'(bus1.trace_valid), 32'(exp_q.size() != 0));
      pop_m = (exp_q.size() != 0) && bus1.trace_ready;
      if (pop_m) begin
        e = exp_q.pop_front();
        chk("sb_addr", bus1.trace_addr, e.addr);
        chk("sb_data", bus1.trace_data, e.data);
        chk("sb_size", 32'(bus1.trace_size), 32'(e.size));
        chk("sb_seq",  32'(bus1.trace_seq), 32'(e.seq));
      end
      if (bus1.write_enable && en1) begin
        if (exp_q.size() < DEPTH) begin
          e.addr = bus1.addr_to_mem;
          e.data = bus1.data_to_mem;
          e.size = bus1.byte_to_mem ? 2'd2 : (bus1.half_word_to_mem ? 2'd1 : 2'd0);
          e.seq  = mseq;
          exp_q.push_back(e);
        end else begin
          if (mdrop != 16'hFFFF) mdrop = mdrop + 16'd1;
          movf = 1'b1;
        end
        mseq = mseq + 16'd1;
      end
    end
  end

  always @(negedge clock) begin
    if (reset) assert (!$isunknown(bus1.write_enable) && !$isunknown(bus2.write_enable))
      else $error("write_enable unknown after reset");
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        b;
    logic        h;
    logic [1:0]  size;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{addr: 32'h2004, data: 32'h0000_00A5, b: 1'b1, h: 1'b1, size: 2'd2};
    vecs[1] = '{addr: 32'h2006, data: 32'h0000_BEEF, b: 1'b0, h: 1'b1, size: 2'd1};
    vecs[2] = '{addr: 32'h2008, data: 32'h0000_0077, b: 1'b1, h: 1'b0, size: 2'd2};
    vecs[3] = '{addr: 32'h200C, data: 32'h1234_5678, b: 1'b0, h: 1'b0, size: 2'd0};
    vecs[4] = '{addr: 32'hFFFF_FFFC, data: 32'hCAFE_F00D, b: 1'b0, h: 1'b0, size: 2'd0};

    reset = 1'b0;
    en1 = 1'b1; en2 = 1'b1;
    bus1.addr_to_mem = '0; bus1.data_to_mem = '0; bus1.write_enable = 1'b0;
    bus1.byte_to_mem = 1'b0; bus1.half_word_to_mem = 1'b0; bus1.trace_ready = 1'b0;
    bus2.addr_to_mem = '0; bus2.data_to_mem = '0; bus2.write_enable = 1'b0;
    bus2.byte_to_mem = 1'b0; bus2.half_word_to_mem = 1'b0; bus2.trace_ready = 1'b0;

    // Reset state
    do_reset();
    chk("rst_valid", 32'(bus1.trace_valid), 0);
    chk("rst_level", 32'(lvl1), 0);
    chk("rst_drops", 32'(drop1), 0);
    chk("rst_ovf",   32'(ovf1), 0);
    chk("rst_seq",   32'(bus1.trace_seq), 0);

    // Single word store, popped the following edge
    bus1.trace_ready = 1'b1;
    st1(32'h2000, 32'd13, 1'b0, 1'b0);
    tick();
    bus1.write_enable = 1'b0;
    chk("w_valid", 32'(bus1.trace_valid), 1);
    chk("w_addr",  bus1.trace_addr, 32'h2000);
    chk("w_data",  bus1.trace_data, 32'd13);
    chk("w_size",  32'(bus1.trace_size), 0);
    chk("w_seq",   32'(bus1.trace_seq), 0);
    tick();
    chk("w_level_after_pop", 32'(lvl1), 0);
    chk("w_valid_after_pop", 32'(bus1.trace_valid), 0);

    // Size encoding table, back-to-back with ready held high
    do_reset();
    bus1.trace_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      st1(vecs[i].addr, vecs[i].data, vecs[i].b, vecs[i].h);
      tick();
      chk("v_valid", 32'(bus1.trace_valid), 1);
      chk("v_addr",  bus1.trace_addr, vecs[i].addr);
      chk("v_data",  bus1.trace_data, vecs[i].data);
      chk("v_size",  32'(bus1.trace_size), 32'(vecs[i].size));
      chk("v_seq",   32'(bus1.trace_seq), 32'(i));
      chk("v_level", 32'(lvl1), 1);
    end
    bus1.write_enable = 1'b0;
    tick();
    chk("v_level_end", 32'(lvl1), 0);

    // Overflow: DEPTH+3 stores with no consumer
    do_reset();
    bus1.trace_ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      st1(32'h3000 + 32'(4 * i), 32'(i), 1'b0, 1'b0);
      tick();
    end
    bus1.write_enable = 1'b0;
    chk("of_level", 32'(lvl1), DEPTH);
    chk("of_drops", 32'(drop1), 3);
    chk("of_ovf",   32'(ovf1), 1);
    bus1.trace_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("of_drain_seq", 32'(bus1.trace_seq), 32'(i));
      tick();
    end
    chk("of_level_end", 32'(lvl1), 0);
    chk("of_ovf_sticky", 32'(ovf1), 1);

    // Full FIFO with push and pop on the same edge: no drop
    bus1.trace_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      st1(32'h4000 + 32'(4 * i), 32'd100 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    chk("fp_level_full", 32'(lvl1), DEPTH);
    st1(32'h4100, 32'hDEAD_BEEF, 1'b0, 1'b0);
    bus1.trace_ready = 1'b1;
    tick();
    bus1.write_enable = 1'b0;
    chk("fp_level", 32'(lvl1), DEPTH);
    chk("fp_drops", 32'(drop1), 3);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) begin
        chk("fp_last_data", bus1.trace_data, 32'hDEAD_BEEF);
        chk("fp_last_seq",  32'(bus1.trace_seq), 32'(DEPTH + 3 + DEPTH));
      end
      tick();
    end
    chk("fp_level_end", 32'(lvl1), 0);

    // trace_en low ignores stores
    en1 = 1'b0;
    st1(32'h5000, 32'h55, 1'b0, 1'b0);
    tick();
    bus1.write_enable = 1'b0;
    en1 = 1'b1;
    chk("en_level", 32'(lvl1), 0);

    // Holding ready low keeps the head stable
    bus1.trace_ready = 1'b0;
    st1(32'h6000, 32'hAAAA_5555, 1'b1, 1'b0);
    tick();
    bus1.write_enable = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("hold_addr", bus1.trace_addr, 32'h6000);
    chk("hold_data", bus1.trace_data, 32'hAAAA_5555);
    chk("hold_size", 32'(bus1.trace_size), 2);
    bus1.trace_ready = 1'b1;
    tick();
    chk("hold_drained", 32'(lvl1), 0);
    bus1.trace_ready = 1'b0;

    // Address window on dut2, then asynchronous reset mid-drain
    do_reset();
    bus2.trace_ready = 1'b0;
    st2(32'h1FFC, 32'd1); tick();
    st2(32'h2100, 32'd2); tick();
    st2(32'h2050, 32'd3); tick();
    st2(32'h20FF, 32'd4); tick();
    bus2.write_enable = 1'b0;
    chk("win_level", 32'(lvl2), 2);
    chk("win_addr",  bus2.trace_addr, 32'h2050);
    chk("win_data",  bus2.trace_data, 32'd3);
    chk("win_seq",   32'(bus2.trace_seq), 0);
    bus2.trace_ready = 1'b1;
    tick();
    chk("win_addr2", bus2.trace_addr, 32'h20FF);
    chk("win_seq2",  32'(bus2.trace_seq), 1);
    chk("win_level2", 32'(lvl2), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(bus2.trace_valid), 0);
    chk("arst_level", 32'(lvl2), 0);
    chk("arst_seq",   32'(bus2.trace_seq), 0);
    tick();
    reset = 1'b1;
    bus2.trace_ready = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
